// File: rtl/div_pkg.sv
// Shared FSM encoding and error_o codes for the sequential divider.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_NORM  = 3'd2,
    S_ITER  = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             a,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int CW = $clog2(WIDTH+1);

  // Later (higher) set bits override earlier ones, so the MSB-most one wins.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring sequential divider, signed/unsigned, with optional
// early termination on dividend leading zeros.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             unsigned_mode,
  input  logic             out_type,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       error_o
);

  localparam int CW = $clog2(WIDTH+1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, d_q, mag_n_q, mag_d_q, dvd_q, rem_q, quo_q;
  logic             uns_q, sel_q_q, sn_q, sd_q;
  logic [CW-1:0]    cnt_q, lzc;

  logic             n_neg, d_neg, chk_div0, chk_ovf, chk_zero, chk_done;
  logic [WIDTH-1:0] chk_q, chk_r, fix_q, fix_r, rem_nx;
  logic [1:0]       chk_err;
  logic [CW-1:0]    k_c, shift_c;
  logic [WIDTH:0]   rem_sh, trial;
  logic             qbit;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .a   (mag_n_q),
    .cnt (lzc)
  );

  // Special-case screening on the latched operands
  always_comb begin
    n_neg    = ~uns_q & n_q[WIDTH-1];
    d_neg    = ~uns_q & d_q[WIDTH-1];
    chk_div0 = (d_q == '0);
    chk_ovf  = ~uns_q & (n_q == {1'b1, {(WIDTH-1){1'b0}}}) & (&d_q);
    chk_zero = (n_q == '0);
    chk_done = chk_div0 | chk_ovf | chk_zero;
    chk_q    = '0;
    chk_r    = '0;
    chk_err  = ERR_OK;
    if (chk_div0) begin
      chk_q   = '1;
      chk_r   = n_q;
      chk_err = ERR_DIV0;
    end else if (chk_ovf) begin
      chk_q   = n_q;
      chk_err = ERR_OVF;
    end
  end

  // Iteration count and pre-shift, restoring step, sign fix-up
  always_comb begin
    k_c     = EARLY_TERM ? (CW'(WIDTH) - lzc) : CW'(WIDTH);
    shift_c = EARLY_TERM ? lzc : '0;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, mag_d_q};
    qbit    = ~trial[WIDTH];
    rem_nx  = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    fix_q   = (~uns_q & (sn_q ^ sd_q)) ? -quo_q : quo_q;
    fix_r   = (~uns_q & sn_q) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = S_CHECK;
      S_CHECK: state_d = chk_done ? S_DONE : S_NORM;
      S_NORM:  state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers carry no reset; control below qualifies their use
  always_ff @(posedge clk_i) begin
    case (state_q)
      S_IDLE: if (valid_i) begin
        n_q     <= n_i;
        d_q     <= d_i;
        uns_q   <= unsigned_mode;
        sel_q_q <= out_type;
      end
      S_CHECK: begin
        sn_q    <= n_neg;
        sd_q    <= d_neg;
        mag_n_q <= n_neg ? -n_q : n_q;
        mag_d_q <= d_neg ? -d_q : d_q;
      end
      S_NORM: begin
        dvd_q <= mag_n_q << shift_c;
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= k_c;
      end
      S_ITER: begin
        dvd_q <= dvd_q << 1;
        rem_q <= rem_nx;
        quo_q <= {quo_q[WIDTH-2:0], qbit};
        cnt_q <= cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ready_o  <= 1'b0;
      q_o      <= '0;
      r_o      <= '0;
      result_o <= '0;
      error_o  <= ERR_OK;
    end else begin
      state_q <= state_d;
      ready_o <= 1'b0;
      case (state_q)
        S_CHECK: if (chk_done) begin
          q_o      <= chk_q;
          r_o      <= chk_r;
          result_o <= sel_q_q ? chk_q : chk_r;
          error_o  <= chk_err;
          ready_o  <= 1'b1;
        end
        S_FIX: begin
          q_o      <= fix_q;
          r_o      <= fix_r;
          result_o <= sel_q_q ? fix_q : fix_r;
          error_o  <= ERR_OK;
          ready_o  <= 1'b1;
        end
        S_IDLE, S_NORM, S_ITER, S_DONE: ;
        default: begin
          error_o <= ERR_ILLEGAL;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         unsigned_mode;
  logic         out_type;
  logic [W-1:0] n_i, d_i;
  logic         busy_o, ready_o;
  logic [W-1:0] q_o, r_o, result_o;
  logic [1:0]   error_o;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W), .EARLY_TERM(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .unsigned_mode (unsigned_mode),
    .out_type      (out_type),
    .n_i           (n_i),
    .d_i           (d_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .q_o           (q_o),
    .r_o           (r_o),
    .result_o      (result_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers; latency from bit length.
  function automatic void model(input bit uns, input logic [W-1:0] n, input logic [W-1:0] d,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic [1:0] e, output int lat);
    longint sn, sd, mag;
    int     k;
    sn  = uns ? longint'(n) : longint'($signed(n));
    sd  = uns ? longint'(d) : longint'($signed(d));
    e   = 2'd0;
    lat = 2;
    q   = '0;
    r   = '0;
    if (d == 0) begin
      q = '1;
      r = n;
      e = 2'd1;
    end else if (!uns && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n;
      e = 2'd2;
    end else if (n != 0) begin
      q   = W'(sn / sd);
      r   = W'(sn % sd);
      mag = (sn < 0) ? -sn : sn;
      k   = 0;
      while (mag != 0) begin
        k++;
        mag = mag >> 1;
      end
      lat = k + 4;
    end
  endfunction

  task automatic run_op(input bit uns, input bit ot, input logic [W-1:0] n,
                        input logic [W-1:0] d, input bit noise, input string tag);
    logic [W-1:0] eq, er;
    logic [1:0]   ee;
    int           lat, cyc;
    bit           seen;
    model(uns, n, d, eq, er, ee, lat);
    @(negedge clk_i);
    valid_i = 1'b1; unsigned_mode = uns; out_type = ot; n_i = n; d_i = d;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    seen = 1'b0;
    cyc  = 1;
    while (cyc <= W + 8) begin
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      if (noise) begin
        valid_i = 1'($urandom); n_i = $urandom; d_i = $urandom;
        unsigned_mode = 1'($urandom); out_type = 1'($urandom);
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      check({tag, "_q"}, 64'(q_o), 64'(eq));
      check({tag, "_r"}, 64'(r_o), 64'(er));
      check({tag, "_result"}, 64'(result_o), 64'(ot ? eq : er));
      check({tag, "_err"}, 64'(error_o), 64'(ee));
      if (noise) valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check({tag, "_pulse_len"}, 64'(ready_o), 64'd0);
      check({tag, "_idle_after"}, 64'(busy_o), 64'd0);
    end else begin
      valid_i = 1'b0;
    end
  endtask

  task automatic reset_mid_iter();
    int pulses;
    @(negedge clk_i);
    valid_i = 1'b1; unsigned_mode = 1'b1; out_type = 1'b1;
    n_i = 32'hFFFF_FFFF; d_i = 32'd1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("rst_async_busy", 64'(busy_o), 64'd0);
    check("rst_async_ready", 64'(ready_o), 64'd0);
    check("rst_async_q", 64'(q_o), 64'd0);
    check("rst_async_r", 64'(r_o), 64'd0);
    check("rst_async_result", 64'(result_o), 64'd0);
    check("rst_async_err", 64'(error_o), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    pulses = 0;
    repeat (W + 8) begin
      @(posedge clk_i); #1;
      if (ready_o) pulses++;
    end
    check("rst_no_ready", 64'(pulses), 64'd0);
    run_op(1'b0, 1'b1, 32'd1, 32'd1, 1'b0, "post_rst_1_1");
  endtask

  function automatic logic [W-1:0] pick_n();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 255));
      4:       return W'($urandom) >> $urandom_range(0, 31);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] pick_d();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      3:       return W'($urandom_range(1, 255));
      4:       return W'($urandom) >> $urandom_range(0, 31);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; unsigned_mode = 1'b0; out_type = 1'b0;
    n_i = '0; d_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_q", 64'(q_o), 64'd0);
    check("reset_r", 64'(r_o), 64'd0);
    check("reset_err", 64'(error_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, "u100_7");
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, "s_m7_2");
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, "div0_u");
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, "div0_s");
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_ovf");
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_no_ovf");
    run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, "u_max_1");
    run_op(1'b0, 1'b0, 32'd0, 32'd9, 1'b0, "zero_n");
    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, "s_7_m2");

    reset_mid_iter();

    for (int i = 0; i < 200; i++) begin
      run_op(1'($urandom), 1'($urandom), pick_n(), pick_d(), 1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
